// File: rtl/alu_writeback_stage_if.sv
// Shared ALU types and the valid/ready bundle between the ALU, the writeback stage and the register file.
// The slave modport is the writeback stage; the master modport is the ALU / register-file side.

package instruction_set;

    localparam int WORD_SIZE = 16;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_CMP = 4'd2,
        ALU_INC = 4'd3,
        ALU_DEC = 4'd4,
        ALU_AND = 4'd5,
        ALU_OR  = 4'd6,
        ALU_XOR = 4'd7,
        ALU_SB  = 4'd8,
        ALU_CB  = 4'd9,
        ALU_MOV = 4'd10,
        ALU_SHL = 4'd11,
        ALU_SHR = 4'd12,
        ALU_NOP = 4'd15
    } alu_ops_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } flags_t;

endpackage

interface alu_writeback_stage_if #(
    parameter int WORD_SIZE  = instruction_set::WORD_SIZE,
    parameter int REG_ADDR_W = 4
);
    import instruction_set::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_SIZE-1:0]  in_result;
    flags_t                in_flags;
    alu_ops_t              in_op;
    logic [REG_ADDR_W-1:0] in_dest;
    logic                  in_wr_en;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [WORD_SIZE-1:0]  wb_data;

    modport master (
        output in_valid, in_result, in_flags, in_op, in_dest, in_wr_en, wb_ready,
        input  in_ready, wb_valid, wb_dest, wb_data
    );

    modport slave (
        input  in_valid, in_result, in_flags, in_op, in_dest, in_wr_en, wb_ready,
        output in_ready, wb_valid, wb_dest, wb_data
    );

endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: commits architectural flags, evaluates branch conditions on them,
// and buffers register-file writes in a 2-entry FIFO so one stalled write does not stall the ALU.

module alu_writeback_stage #(
    parameter int WORD_SIZE  = instruction_set::WORD_SIZE,
    parameter int REG_ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    alu_writeback_stage_if.slave    bus,
    input  logic [2:0]              cond,
    output logic                    cond_true,
    output instruction_set::flags_t flags_q,
    output logic [15:0]             retired
);
    import instruction_set::*;

    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [REG_ADDR_W-1:0] dest_mem [2];
    logic [WORD_SIZE-1:0]  data_mem [2];

    logic accept;
    logic commit;
    logic push;
    logic pop;

    // in_ready comes from the registered count only, never from wb_ready.
    assign bus.in_ready = (count < 2'd2);
    assign bus.wb_valid = (count != 2'd0);
    assign bus.wb_dest  = dest_mem[rd_ptr];
    assign bus.wb_data  = data_mem[rd_ptr];

    assign accept = bus.in_valid && bus.in_ready;
    assign commit = accept && !flush;
    assign push   = commit && bus.in_wr_en;
    assign pop    = bus.wb_valid && bus.wb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            // NOTE: the storage is reset too, because wb_dest/wb_data read straight from it
            // and must show zero out of reset; without that they would expose stale contents.
            for (int i = 0; i < 2; i++) begin
                dest_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                dest_mem[wr_ptr] <= bus.in_dest;
                data_mem[wr_ptr] <= bus.in_result;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Logical ops and inc/dec only refresh Z and N; C and V keep their committed values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (commit) begin
            case (bus.in_op)
                ALU_ADD, ALU_SUB, ALU_CMP: begin
                    flags_q <= bus.in_flags;
                end
                ALU_INC, ALU_DEC, ALU_AND, ALU_OR, ALU_XOR, ALU_SB, ALU_CB: begin
                    flags_q.zero     <= bus.in_flags.zero;
                    flags_q.negative <= bus.in_flags.negative;
                end
                default: begin
                    flags_q <= flags_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= 16'd0;
        end else if (commit && (retired != 16'hFFFF)) begin
            retired <= retired + 16'd1;
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path drives cond_true and no latch is inferred.
        cond_true = 1'b0;
        case (cond)
            3'd0:    cond_true = 1'b1;
            3'd1:    cond_true = flags_q.zero;
            3'd2:    cond_true = !flags_q.zero;
            3'd3:    cond_true = flags_q.carry;
            3'd4:    cond_true = !flags_q.carry;
            3'd5:    cond_true = flags_q.negative;
            3'd6:    cond_true = flags_q.overflow;
            default: cond_true = flags_q.negative ^ flags_q.overflow;
        endcase
    end

endmodule
